// File: rtl/max_unpooling_mult.sv
// Max-unpooling: scatters a pooled ROWS x IN_COLS tile into ROWS x 2*IN_COLS rows,
// CHUNK columns per row per cycle; the argmax position gets the value and its partner gets zero.
module max_unpooling_mult #(
  parameter int ROWS    = 4,
  parameter int IN_COLS = 46,
  parameter int DATA_W  = 32,
  parameter int CHUNK   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [ROWS*IN_COLS*DATA_W-1:0]   pooled_data,
  input  logic [ROWS*IN_COLS-1:0]          max_sel,
  output logic                             valid_o,
  output logic [ROWS*2*IN_COLS*DATA_W-1:0] multi_output_data
);

  localparam int NCHUNK = IN_COLS / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [ROWS*IN_COLS*DATA_W-1:0]    data_q, data_d;
  logic [ROWS*IN_COLS-1:0]           sel_q, sel_d;
  logic [ROWS*2*IN_COLS*DATA_W-1:0]  out_q, out_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sel_d   = sel_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          data_d  = pooled_data;
          sel_d   = max_sel;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Every column compares its constant chunk number against cnt, so all indices stay static.
        for (int r = 0; r < ROWS; r++) begin
          for (int j = 0; j < IN_COLS; j++) begin
            if (cnt_q == CNT_W'(j / CHUNK)) begin
              out_d[(r*2*IN_COLS + 2*j)*DATA_W +: DATA_W] =
                sel_q[r*IN_COLS + j] ? '0 : data_q[(r*IN_COLS + j)*DATA_W +: DATA_W];
              out_d[(r*2*IN_COLS + 2*j + 1)*DATA_W +: DATA_W] =
                sel_q[r*IN_COLS + j] ? data_q[(r*IN_COLS + j)*DATA_W +: DATA_W] : '0;
            end
          end
        end
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready_o           = (state_q == IDLE);
  assign valid_o           = (state_q == DONE);
  assign multi_output_data = out_q;

endmodule

// File: tb/tb_max_unpooling_mult.sv
// Randomized and directed bench for max_unpooling_mult against an array-level scatter model.
module tb_max_unpooling_mult;
  localparam int ROWS     = 4;
  localparam int IN_COLS  = 46;
  localparam int DATA_W   = 32;
  localparam int OUT_COLS = 2 * IN_COLS;

  typedef logic [DATA_W-1:0] vals_t [ROWS][IN_COLS];
  typedef logic              sels_t [ROWS][IN_COLS];

  logic clk = 1'b0;
  logic reset;
  logic valid_i;
  logic ready_o;
  logic [ROWS*IN_COLS*DATA_W-1:0]  pooled_data;
  logic [ROWS*IN_COLS-1:0]         max_sel;
  logic valid_o;
  logic [ROWS*OUT_COLS*DATA_W-1:0] multi_output_data;

  int n_checks = 0;
  int n_errors = 0;

  vals_t va, vb;
  sels_t sa, sb;

  max_unpooling_mult #(.ROWS(ROWS), .IN_COLS(IN_COLS), .DATA_W(DATA_W), .CHUNK(2)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .pooled_data(pooled_data), .max_sel(max_sel),
    .valid_o(valid_o), .multi_output_data(multi_output_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_tile(input vals_t v, input sels_t s);
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < IN_COLS; j++) begin
        pooled_data[(r*IN_COLS + j)*DATA_W +: DATA_W] = v[r][j];
        max_sel[r*IN_COLS + j] = s[r][j];
      end
  endtask

  // Reference: output column c of row r comes from pooled column c/2; it carries the
  // value only when the parity of c matches the recorded argmax bit, otherwise zero.
  task automatic check_tile(input string tag, input vals_t v, input sels_t s);
    logic [DATA_W-1:0] exp;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < OUT_COLS; c++) begin
        exp = ((c % 2) == int'(s[r][c/2])) ? v[r][c/2] : '0;
        check($sformatf("%s r%0d c%0d", tag, r, c),
              multi_output_data[(r*OUT_COLS + c)*DATA_W +: DATA_W], exp);
      end
  endtask

  task automatic gen_random(output vals_t v, output sels_t s);
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < IN_COLS; j++) begin
        case ($urandom_range(0, 7))
          0:       v[r][j] = '0;
          1:       v[r][j] = 32'h7FC0_0001;
          2:       v[r][j] = 32'h8000_0000 | $urandom;
          default: v[r][j] = $urandom;
        endcase
        s[r][j] = 1'($urandom_range(0, 1));
      end
  endtask

  // Present one tile, then expect valid_o exactly 23 edges after acceptance and idle on the next.
  task automatic run_tile(input string tag, input vals_t v, input sels_t s);
    int  n;
    bit  seen;
    bit  rdy_bad;
    @(negedge clk);
    drive_tile(v, s);
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check({tag, " ready_o after accept"}, ready_o, 0);
    n = 0; seen = 0; rdy_bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (valid_o) begin
        seen = 1;
        break;
      end
      if (ready_o) rdy_bad = 1;
    end
    check({tag, " valid_o seen"}, seen, 1);
    check({tag, " latency"}, n, 23);
    check({tag, " ready_o low while busy"}, rdy_bad, 0);
    check({tag, " ready_o during valid"}, ready_o, 0);
    check_tile(tag, v, s);
    @(posedge clk);
    #1;
    check({tag, " valid_o one cycle"}, valid_o, 0);
    check({tag, " ready_o back"}, ready_o, 1);
  endtask

  initial begin
    int n;
    int pulses;
    bit seen;

    reset = 1'b0;
    valid_i = 1'b0;
    pooled_data = '0;
    max_sel = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset valid_o", valid_o, 0);
    check("reset ready_o", ready_o, 1);
    check("reset data zero", |multi_output_data, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset ready_o", ready_o, 1);

    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < IN_COLS; j++) begin
        va[r][j] = 32'h8C00_0000;
        sa[r][j] = 1'b0;
      end
    run_tile("even", va, sa);

    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < IN_COLS; j++) begin
        va[r][j] = 32'h0B00_0000;
        sa[r][j] = 1'b1;
      end
    run_tile("odd", va, sa);

    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < IN_COLS; j++) begin
        va[r][j] = {8'(r), 24'(j)};
        sa[r][j] = 1'(j ^ r);
      end
    run_tile("mixed", va, sa);

    for (int t = 0; t < 3; t++) begin
      gen_random(va, sa);
      run_tile($sformatf("rand%0d", t), va, sa);
    end

    // Back-to-back: B held on valid_i from E1 must not disturb A and is taken at E25.
    gen_random(va, sa);
    gen_random(vb, sb);
    @(negedge clk);
    drive_tile(va, sa);
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    drive_tile(vb, sb);
    n = 0; seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (valid_o) begin
        seen = 1;
        break;
      end
    end
    check("hs A seen", seen, 1);
    check("hs A latency", n, 23);
    check_tile("hsA", va, sa);
    n = 0; seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 2) begin
        check("hs B accepted at E25", ready_o, 0);
        valid_i = 1'b0;
      end
      if (valid_o) begin
        seen = 1;
        break;
      end
    end
    check("hs B seen", seen, 1);
    check("hs B gap", n, 25);
    check_tile("hsB", vb, sb);
    @(posedge clk);
    #1;
    check("hs B one cycle", valid_o, 0);

    // Abort mid-tile with reset at E10.
    gen_random(va, sa);
    @(negedge clk);
    drive_tile(va, sa);
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort data zero", |multi_output_data, 0);
    check("abort ready_o", ready_o, 1);
    check("abort valid_o", valid_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid_o) pulses++;
    end
    check("abort no pulse", pulses, 0);
    check("abort still idle", ready_o, 1);
    gen_random(va, sa);
    run_tile("after_abort", va, sa);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
